// File: rtl/crosswalk_scheduler.sv
// Pedestrian crossing scheduler: latches north/west button edges, arbitrates them round-robin,
// requests a safe traffic phase and sequences WALK, flashing-stop clearance and solid STOP.
module crosswalk_scheduler #(
   parameter int unsigned WALK_SECS  = 7,
   parameter int unsigned CLEAR_SECS = 5
) (
   input  logic clk_50_mhz,
   input  logic reset_n,
   input  logic tick_1hz,
   input  logic nrth_req,
   input  logic west_req,
   input  logic nrth_safe,
   input  logic west_safe,
   output logic call_nrth,
   output logic call_west,
   output logic walk_nrth,
   output logic stop_nrth,
   output logic walk_west,
   output logic stop_west,
   output logic busy,
   output logic abort_pulse
);

   localparam int unsigned MaxSecs = (WALK_SECS > CLEAR_SECS) ? WALK_SECS : CLEAR_SECS;
   localparam int unsigned CNT_W   = $clog2(MaxSecs + 1);
   localparam logic [CNT_W-1:0] WalkLoad  = CNT_W'(WALK_SECS);
   localparam logic [CNT_W-1:0] ClearLoad = CNT_W'(CLEAR_SECS);
   localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

   typedef enum logic [2:0] {StIdle, StWaitSafe, StWalk, StClear, StAbort} state_e;

   // Bit 0 is the north crossing, bit 1 the west crossing throughout.
   state_e           state_q, state_d;
   logic [1:0]       pending_q, pending_d;
   logic             rr_ptr_q, rr_ptr_d;
   logic             grant_q, grant_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             flash_q, flash_d;
   logic [1:0]       req_q;
   logic [1:0]       walk_q, walk_d;
   logic [1:0]       stop_q, stop_d;
   logic [1:0]       call_q, call_d;
   logic             busy_q, busy_d;
   logic             abort_q, abort_d;

   logic [1:0] req, safe, edge_det, served, gsel, clr_sel;

   always_comb begin
      req      = {west_req, nrth_req};
      safe     = {west_safe, nrth_safe};
      edge_det = req & ~req_q;
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      count_d  = count_q;
      flash_d  = flash_q;
      // A press for the crossing already being served (before its walk ends) is absorbed.
      served    = (state_q == StWaitSafe || state_q == StWalk) ? (2'b01 << grant_q) : 2'b00;
      pending_d = pending_q | (edge_det & ~served);

      unique case (state_q)
         StIdle: begin
            if (|pending_q) begin
               state_d = StWaitSafe;
               grant_d = (&pending_q) ? rr_ptr_q : pending_q[1];
            end
         end
         StWaitSafe: begin
            if (safe[grant_q]) begin
               state_d            = StWalk;
               count_d            = WalkLoad;
               pending_d[grant_q] = 1'b0;
            end
         end
         StWalk: begin
            if (!safe[grant_q]) begin
               state_d = StAbort;
            end else if (tick_1hz) begin
               if (count_q == CntOne) begin
                  state_d = StClear;
                  count_d = ClearLoad;
                  flash_d = 1'b1;
               end else begin
                  count_d = count_q - CntOne;
               end
            end
         end
         StClear: begin
            if (!safe[grant_q]) begin
               state_d = StAbort;
            end else if (tick_1hz) begin
               flash_d = ~flash_q;
               if (count_q == CntOne) begin
                  state_d  = StIdle;
                  rr_ptr_d = ~grant_q;
               end else begin
                  count_d = count_q - CntOne;
               end
            end
         end
         StAbort: begin
            state_d            = StIdle;
            pending_d[grant_q] = 1'b1;
         end
         default: state_d = StIdle;
      endcase

      // Lamps and calls are registered from next-state so they track the state register.
      gsel    = 2'b01 << grant_d;
      walk_d  = (state_d == StWalk) ? gsel : 2'b00;
      clr_sel = (state_d == StClear) ? gsel : 2'b00;
      stop_d  = ~walk_d & ~(clr_sel & {2{~flash_d}});
      call_d  = pending_d | ((state_d != StIdle) ? gsel : 2'b00);
      busy_d  = (state_d != StIdle);
      abort_d = (state_d == StAbort);
   end

   always_ff @(posedge clk_50_mhz or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         pending_q <= 2'b00;
         rr_ptr_q  <= 1'b0;
         grant_q   <= 1'b0;
         count_q   <= '0;
         flash_q   <= 1'b1;
         req_q     <= 2'b00;
         walk_q    <= 2'b00;
         stop_q    <= 2'b11;
         call_q    <= 2'b00;
         busy_q    <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         rr_ptr_q  <= rr_ptr_d;
         grant_q   <= grant_d;
         count_q   <= count_d;
         flash_q   <= flash_d;
         req_q     <= req;
         walk_q    <= walk_d;
         stop_q    <= stop_d;
         call_q    <= call_d;
         busy_q    <= busy_d;
         abort_q   <= abort_d;
      end
   end

   assign call_nrth   = call_q[0];
   assign call_west   = call_q[1];
   assign walk_nrth   = walk_q[0];
   assign stop_nrth   = stop_q[0];
   assign walk_west   = walk_q[1];
   assign stop_west   = stop_q[1];
   assign busy        = busy_q;
   assign abort_pulse = abort_q;

endmodule
